dma_host_ctrl: RTL and testbench
================================

// Module: dma_host_ctrl
// PURPOSE
//  CPU-side responder for the DMA engine's bus-request protocol. On a device-ready
//  interrupt it issues a one-cycle cmd to the DMA, arbitrates memory ownership
//  (BR in, BG out) against the CPU's in-flight accesses, stalls the CPU while the
//  DMA owns the bus, and records completion/timeout status. Sits between CPU
//  datapath control, the DMA engine and the external device's interrupt line.
// PARAMETERS
//  TIMEOUT  256  max cycles from cmd to DMA end-interrupt before declaring error
//  TMO_W    9    width of watchdog counter (must hold TIMEOUT)
// PORTS
//  CLK           in   1   system clock, rising edge
//  reset_n       in   1   asynchronous active-low reset
//  dev_int       in   1   external device has a transfer ready (level, sampled)
//  BR            in   1   bus request from DMA
//  dma_int       in   1   DMA end-of-transfer interrupt (1-cycle pulse)
//  cpu_mem_busy  in   1   CPU has a memory access in flight this cycle
//  done_clr      in   1   CPU acknowledges status; clears dma_done/dma_err
//  cmd           out  1   start pulse to DMA
//  BG            out  1   bus grant to DMA
//  cpu_hold      out  1   CPU must not start a new memory access
//  dma_done      out  1   sticky: last transfer finished normally
//  dma_err       out  1   sticky: last transfer timed out
//  grant_cnt     out  4   number of BR/BG grant episodes in current/last transfer
// BEHAVIOUR
//  Reset: state IDLE; cmd=0, BG=0, cpu_hold=0, dma_done=0, dma_err=0,
//   grant_cnt=0, watchdog=0, pending=0. Reset mid-transfer drops BG immediately.
//  FSM (all outputs registered):
//   IDLE : dev_int=1 (or pending=1) -> CMD; clear grant_cnt, watchdog, pending.
//   CMD  : cmd=1 for exactly this cycle -> WAIT.
//   WAIT : BR=1 & cpu_mem_busy=0 -> GRANT (BG=1 next cycle, grant_cnt+1).
//          BR=1 & cpu_mem_busy=1 -> stay; BG waits until CPU access retires.
//   GRANT: BG=1 while BR=1; BR=0 -> WAIT with BG=0 the following cycle.
//   Any of CMD/WAIT/GRANT: dma_int=1 -> DONE (wins over simultaneous BR).
//   DONE : BG=0, dma_done<=1 -> IDLE.
//   ERR  : BG=0, dma_err<=1 -> IDLE. Entered when watchdog reaches TIMEOUT in
//          WAIT or GRANT without dma_int; dma_int in the same cycle wins (DONE).
//  cpu_hold = BR | BG (combinational OR of input and registered BG); asserts
//   the cycle BR rises so CPU issues no new access; CPU's busy access finishes.
//  Latency: BR high (cpu_mem_busy low) -> BG high next edge; BR low -> BG low
//   next edge. DMA may re-request (one episode per 4-word chunk); each counts.
//  Watchdog increments each cycle in CMD/WAIT/GRANT, saturates at TIMEOUT.
//  grant_cnt saturates at 15; holds value after DONE/ERR until next CMD.
//  dev_int while not IDLE: sets pending; serviced on return to IDLE (one only).
//  done_clr clears dma_done and dma_err; same-cycle set has priority over clear.
//  BR outside WAIT/GRANT (IDLE, CMD) is ignored: no BG issued.
// STRUCTURE
//  Shared package/header: state encoding (IDLE,CMD,WAIT,GRANT,DONE,ERR),
//   WORD_SIZE, DMA chunk constants (4 words/chunk, 3 chunks).
//  One sub-module: dma_watchdog (load/enable/saturating counter, expired flag).
// TESTING
//  Normal: dev_int 1 cyc -> cmd pulse 1 cyc; 3 BR episodes of 4 cyc each ->
//   BG follows BR by 1 cyc each; dma_int -> dma_done=1, grant_cnt=3.
//  Contention: BR rises while cpu_mem_busy=1 for 3 cyc -> cpu_hold=1 at once,
//   BG=0 for those 3 cyc, BG=1 the cycle after busy drops.
//  Timeout: cmd issued, no BR/dma_int -> ERR at cycle TIMEOUT, dma_err=1, BG=0;
//   done_clr -> dma_err=0.
//  Simultaneous: dma_int and BR rising same cycle -> DONE, BG never asserts.
//  Pending: dev_int during GRANT -> after DONE/IDLE, second cmd pulse issued,
//   grant_cnt reset to 0.
//  Reset mid-GRANT: reset_n low async -> BG, cpu_hold(BG part)=0 immediately,
//   all status cleared; no cmd after release until new dev_int.

Source files
------------

// File: rtl/dma_host_ctrl_pkg.sv
// Shared state encoding, transfer geometry and small helpers for the
// CPU-side DMA bus-request responder.
package dma_host_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_GRANT = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   localparam int WORD_SIZE   = 32;
   localparam int CHUNK_WORDS = 4;
   localparam int NUM_CHUNKS  = 3;

   localparam int                GCNT_W   = 4;
   localparam logic [GCNT_W-1:0] GCNT_MAX = 4'd15;

   // Grant-episode counter increment that sticks at its maximum.
   function automatic logic [GCNT_W-1:0] gcnt_inc(input logic [GCNT_W-1:0] v);
      logic [GCNT_W-1:0] r;
      if (v == GCNT_MAX) begin
         r = v;
      end else begin
         r = v + 4'd1;
      end
      return r;
   endfunction

   // True for the states in which a transfer is outstanding and the watchdog runs.
   function automatic logic in_transfer(input state_e s);
      logic r;
      case (s)
         ST_CMD, ST_WAIT, ST_GRANT: r = 1'b1;
         default:                   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dma_host_ctrl_watchdog.sv
// Saturating cycle counter used to bound how long a DMA transfer may remain
// outstanding; expired_o is high while the count sits at TIMEOUT.
module dma_watchdog #(
   parameter int TIMEOUT = 256,
   parameter int TMO_W   = 9
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT);
   localparam logic [TMO_W-1:0] ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] ZERO  = {TMO_W{1'b0}};

   logic [TMO_W-1:0] count_q;
   logic [TMO_W-1:0] count_d;

   // Restart on a new command, otherwise count up and park at the limit.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = ZERO;
      end else if (en_i && (count_q != LIMIT)) begin
         count_d = count_q + ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Counter state.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= ZERO;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/dma_host_ctrl.sv
// CPU-side responder for the DMA bus-request protocol: launches a transfer on a
// device interrupt, arbitrates BR/BG against CPU memory traffic, records status.
module dma_host_ctrl
   import dma_host_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int TMO_W   = 9
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic              dev_int,
   input  logic              BR,
   input  logic              dma_int,
   input  logic              cpu_mem_busy,
   input  logic              done_clr,
   output logic              cmd,
   output logic              BG,
   output logic              cpu_hold,
   output logic              dma_done,
   output logic              dma_err,
   output logic [GCNT_W-1:0] grant_cnt
);

   state_e              state_q;
   logic                cmd_q;
   logic                bg_q;
   logic                done_q;
   logic                err_q;
   logic                pending_q;
   logic [GCNT_W-1:0]   gcnt_q;

   logic                start_s;
   logic                wd_en_s;
   logic                wd_expired_s;

   assign start_s = (state_q == ST_IDLE) && (dev_int || pending_q);
   assign wd_en_s = in_transfer(state_q);

   dma_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TMO_W   (TMO_W)
   ) u_watchdog (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .load_i    (start_s),
      .en_i      (wd_en_s),
      .expired_o (wd_expired_s)
   );

   // Transfer sequencing FSM; every output except cpu_hold comes from a flop here.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= 1'b0;
         bg_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         pending_q <= 1'b0;
         gcnt_q    <= 4'd0;
      end else begin
         cmd_q <= 1'b0;
         // A second interrupt arriving mid-transfer is remembered once.
         if (dev_int && (state_q != ST_IDLE)) begin
            pending_q <= 1'b1;
         end
         // Status acknowledge; any set below in the same cycle overrides it.
         if (done_clr) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_q   <= ST_CMD;
                  cmd_q     <= 1'b1;
                  gcnt_q    <= 4'd0;
                  pending_q <= 1'b0;
               end
            end
            ST_CMD: begin
               if (dma_int) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dma_int) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else if (wd_expired_s) begin
                  state_q <= ST_ERR;
                  err_q   <= 1'b1;
               end else if (BR && !cpu_mem_busy) begin
                  state_q <= ST_GRANT;
                  bg_q    <= 1'b1;
                  gcnt_q  <= gcnt_inc(gcnt_q);
               end
            end
            ST_GRANT: begin
               if (dma_int) begin
                  state_q <= ST_DONE;
                  bg_q    <= 1'b0;
                  done_q  <= 1'b1;
               end else if (wd_expired_s) begin
                  state_q <= ST_ERR;
                  bg_q    <= 1'b0;
                  err_q   <= 1'b1;
               end else if (!BR) begin
                  state_q <= ST_WAIT;
                  bg_q    <= 1'b0;
               end
            end
            ST_DONE, ST_ERR: begin
               state_q <= ST_IDLE;
               bg_q    <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               bg_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cmd       = cmd_q;
   assign BG        = bg_q;
   // BR itself holds the CPU off in the very cycle the DMA asks for the bus.
   assign cpu_hold  = BR | bg_q;
   assign dma_done  = done_q;
   assign dma_err   = err_q;
   assign grant_cnt = gcnt_q;

endmodule

// File: tb/tb_dma_host_ctrl.sv
// Bench for dma_host_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transfer-level reference model.
module tb_dma_host_ctrl;

   localparam int TIMEOUT = 256;

   logic       CLK          = 1'b0;
   logic       reset_n      = 1'b1;
   logic       dev_int      = 1'b0;
   logic       BR           = 1'b0;
   logic       dma_int      = 1'b0;
   logic       cpu_mem_busy = 1'b0;
   logic       done_clr     = 1'b0;
   logic       cmd, BG, cpu_hold, dma_done, dma_err;
   logic [3:0] grant_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: one transfer at a time, tracked by its age since cmd.
   bit m_xfer;    // transfer outstanding (cmd cycle through last bus cycle)
   bit m_ending;  // single wrap-up cycle after completion or timeout
   bit m_cmd, m_bg, m_done, m_err, m_pend;
   int m_age, m_grants;

   dma_host_ctrl #(.TIMEOUT(TIMEOUT), .TMO_W(9)) dut (
      .CLK(CLK), .reset_n(reset_n), .dev_int(dev_int), .BR(BR), .dma_int(dma_int),
      .cpu_mem_busy(cpu_mem_busy), .done_clr(done_clr), .cmd(cmd), .BG(BG),
      .cpu_hold(cpu_hold), .dma_done(dma_done), .dma_err(dma_err), .grant_cnt(grant_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_xfer = 0; m_ending = 0; m_cmd = 0; m_bg = 0;
      m_done = 0; m_err = 0; m_pend = 0; m_age = 0; m_grants = 0;
   endfunction

   function automatic void model_step(input bit dev, input bit br, input bit dint,
                                      input bit busy, input bit clr);
      bit launch = 0;
      if (clr) begin
         m_done = 0;
         m_err  = 0;
      end
      if (m_ending) begin
         m_ending = 0;
         m_bg     = 0;
         if (dev) m_pend = 1;
      end else if (!m_xfer) begin
         if (dev || m_pend) begin
            m_xfer = 1; m_age = 0; m_grants = 0; m_pend = 0; launch = 1;
         end
      end else begin
         if (dev) m_pend = 1;
         if (dint) begin
            m_done = 1; m_bg = 0; m_xfer = 0; m_ending = 1;
         end else if (!m_cmd && m_age >= TIMEOUT) begin
            m_err = 1; m_bg = 0; m_xfer = 0; m_ending = 1;
         end else if (!m_cmd) begin
            if (m_bg && !br) begin
               m_bg = 0;
            end else if (!m_bg && br && !busy) begin
               m_bg = 1;
               m_grants = (m_grants < 15) ? m_grants + 1 : 15;
            end
         end
         if (m_age < TIMEOUT) m_age = m_age + 1;
      end
      m_cmd = launch;
   endfunction

   // One clock: model advances with the inputs the DUT sampled at this edge.
   task automatic tick();
      bit d = dev_int, b = BR, di = dma_int, bu = cpu_mem_busy, c = done_clr;
      @(posedge CLK);
      if (!reset_n) model_reset();
      else model_step(d, b, di, bu, c);
      #1;
   endtask

   always @(negedge CLK) begin
      chk("cmd", 32'(cmd), 32'(m_cmd));
      chk("BG", 32'(BG), 32'(m_bg));
      chk("cpu_hold", 32'(cpu_hold), 32'(BR | m_bg));
      chk("dma_done", 32'(dma_done), 32'(m_done));
      chk("dma_err", 32'(dma_err), 32'(m_err));
      chk("grant_cnt", 32'(grant_cnt), 32'(m_grants));
   end

   initial begin
      int n;
      model_reset();
      #1 reset_n = 1'b0;
      repeat (3) tick();
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_BG", 32'(BG), 32'd0);
      chk("rst_grant", 32'(grant_cnt), 32'd0);
      reset_n = 1'b1;
      tick();

      // Normal transfer: three 4-cycle BR episodes.
      dev_int = 1'b1; tick();
      chk("norm_cmd", 32'(cmd), 32'd1);
      dev_int = 1'b0; tick();
      chk("norm_cmd_off", 32'(cmd), 32'd0);
      for (int e = 0; e < 3; e++) begin
         BR = 1'b1;
         repeat (4) tick();
         BR = 1'b0;
         repeat (2) tick();
      end
      dma_int = 1'b1; tick();
      dma_int = 1'b0; tick();
      chk("norm_grant", 32'(grant_cnt), 32'd3);
      chk("norm_model_grant", 32'(m_grants), 32'd3);
      chk("norm_done", 32'(dma_done), 32'd1);
      done_clr = 1'b1; tick();
      done_clr = 1'b0;
      chk("clr_done", 32'(dma_done), 32'd0);

      // Contention: BR rises while the CPU finishes an access.
      dev_int = 1'b1; tick();
      dev_int = 1'b0; tick();
      BR = 1'b1; cpu_mem_busy = 1'b1;
      #1;
      chk("cont_hold", 32'(cpu_hold), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("cont_bg_low", 32'(BG), 32'd0);
      end
      cpu_mem_busy = 1'b0; tick();
      chk("cont_bg_high", 32'(BG), 32'd1);
      BR = 1'b0; tick();
      dma_int = 1'b1; tick();
      dma_int = 1'b0; tick();

      // Timeout: no BR and no end interrupt.
      done_clr = 1'b1; tick();
      done_clr = 1'b0;
      dev_int = 1'b1; tick();
      dev_int = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (dma_err !== 1'b1 && n < 400);
      chk("tmo_cycles", 32'(n), 32'd257);
      chk("tmo_bg", 32'(BG), 32'd0);
      done_clr = 1'b1; tick();
      done_clr = 1'b0;
      chk("tmo_clr", 32'(dma_err), 32'd0);
      tick();

      // Simultaneous end interrupt and BR.
      dev_int = 1'b1; tick();
      dev_int = 1'b0; tick();
      BR = 1'b1; dma_int = 1'b1; tick();
      chk("sim_bg", 32'(BG), 32'd0);
      chk("sim_done", 32'(dma_done), 32'd1);
      dma_int = 1'b0; tick();
      chk("sim_bg2", 32'(BG), 32'd0);
      BR = 1'b0; tick();

      // Pending interrupt arriving during GRANT.
      dev_int = 1'b1; tick();
      dev_int = 1'b0; tick();
      BR = 1'b1; tick();
      dev_int = 1'b1; tick();
      dev_int = 1'b0; dma_int = 1'b1; tick();
      dma_int = 1'b0; BR = 1'b0;
      n = 0;
      while (cmd !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("pend_cmd", 32'(cmd), 32'd1);
      chk("pend_model_cmd", 32'(m_cmd), 32'd1);
      chk("pend_grant", 32'(grant_cnt), 32'd0);
      tick();
      BR = 1'b1; tick();
      chk("pend_bg", 32'(BG), 32'd1);

      // Asynchronous reset while granted.
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      chk("arst_bg", 32'(BG), 32'd0);
      chk("arst_hold_br", 32'(cpu_hold), 32'd1);
      BR = 1'b0;
      #1;
      chk("arst_hold", 32'(cpu_hold), 32'd0);
      chk("arst_done", 32'(dma_done), 32'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("arst_no_cmd", 32'(cmd), 32'd0);
      end

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         dev_int      = ($urandom_range(0, 19) == 0);
         dma_int      = ($urandom_range(0, 39) == 0);
         cpu_mem_busy = ($urandom_range(0, 2) == 0);
         done_clr     = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0) BR = ~BR;
         tick();
      end
      dev_int = 1'b0; dma_int = 1'b0; cpu_mem_busy = 1'b0; done_clr = 1'b0; BR = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
